// File: rtl/front_panel.sv
// Front panel for the TSC microcomputer: button debounce and step pulses, switch synchronizers,
// a 4-digit multiplexed hex display of output_port, and a PC LED latch.
module front_panel #(
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int SCAN_DIV        = 4
) (
    input  logic        clk,
    input  logic        reset_cpu,
    input  logic        btn_step,
    input  logic        sw_run,
    input  logic        sw_wwd,
    input  logic [1:0]  sw_regsel,
    input  logic [15:0] output_port,
    input  logic [7:0]  PC_below8bit,
    output logic        cpu_enable,
    output logic        wwd_enable,
    output logic [1:0]  register_selection,
    output logic [3:0]  seg_an,
    output logic [6:0]  seg_cat,
    output logic [7:0]  led,
    output logic [15:0] step_count
);

    localparam int DW = $clog2(DEBOUNCE_CYCLES);
    localparam int PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [DW-1:0] DB_LAST   = DW'(DEBOUNCE_CYCLES - 1);
    localparam logic [PW-1:0] SCAN_LAST = PW'(SCAN_DIV - 1);

    logic [1:0]    btn_sync;
    logic [1:0]    run_sync;
    logic [1:0]    wwd_sync;
    logic [1:0]    regsel_s1;
    logic [1:0]    regsel_s2;
    logic [DW-1:0] db_cnt;
    logic          db_level;
    logic          db_prev;
    logic [PW-1:0] presc;
    logic [1:0]    digit_idx;
    logic [15:0]   snapshot;

    logic [PW-1:0] presc_nxt;
    logic [1:0]    idx_nxt;
    logic [15:0]   snap_nxt;
    logic [3:0]    nibble_nxt;

    function automatic logic [6:0] hex7(input logic [3:0] v);
        logic [6:0] s;
        case (v)
            4'h0: s = 7'b1000000;
            4'h1: s = 7'b1111001;
            4'h2: s = 7'b0100100;
            4'h3: s = 7'b0110000;
            4'h4: s = 7'b0011001;
            4'h5: s = 7'b0010010;
            4'h6: s = 7'b0000010;
            4'h7: s = 7'b1111000;
            4'h8: s = 7'b0000000;
            4'h9: s = 7'b0010000;
            4'hA: s = 7'b0001000;
            4'hB: s = 7'b0000011;
            4'hC: s = 7'b1000110;
            4'hD: s = 7'b0100001;
            4'hE: s = 7'b0000110;
            default: s = 7'b0001110;
        endcase
        return s;
    endfunction

    // Display outputs are registered from next-state values so a fresh snapshot
    // shows on digit 0 on the same edge the index wraps.
    always_comb begin
        presc_nxt = presc + PW'(1);
        idx_nxt   = digit_idx;
        snap_nxt  = snapshot;
        if (presc == SCAN_LAST) begin
            presc_nxt = '0;
            idx_nxt   = digit_idx + 2'd1;
            if (digit_idx == 2'd3) begin
                snap_nxt = output_port;
            end
        end
        nibble_nxt = snap_nxt[{idx_nxt, 2'b00} +: 4];
    end

    always_ff @(posedge clk or posedge reset_cpu) begin
        if (reset_cpu) begin
            btn_sync           <= '0;
            run_sync           <= '0;
            wwd_sync           <= '0;
            regsel_s1          <= '0;
            regsel_s2          <= '0;
            db_cnt             <= '0;
            db_level           <= 1'b0;
            db_prev            <= 1'b0;
            cpu_enable         <= 1'b0;
            wwd_enable         <= 1'b0;
            register_selection <= '0;
            step_count         <= '0;
            led                <= '0;
            presc              <= '0;
            digit_idx          <= '0;
            snapshot           <= '0;
            seg_an             <= 4'b1110;
            seg_cat            <= 7'b1000000;
        end else begin
            btn_sync  <= {btn_sync[0], btn_step};
            run_sync  <= {run_sync[0], sw_run};
            wwd_sync  <= {wwd_sync[0], sw_wwd};
            regsel_s1 <= sw_regsel;
            regsel_s2 <= regsel_s1;

            wwd_enable         <= wwd_sync[1];
            register_selection <= regsel_s2;
            led                <= PC_below8bit;

            if (btn_sync[1] == db_level) begin
                db_cnt <= '0;
            end else if (db_cnt == DB_LAST) begin
                db_cnt   <= '0;
                db_level <= ~db_level;
            end else begin
                db_cnt <= db_cnt + DW'(1);
            end

            // Edges are tracked in run mode too, so a press made while running
            // cannot leak a pulse after switching back to step mode.
            db_prev    <= db_level;
            cpu_enable <= run_sync[1] | (db_level & ~db_prev);

            if (cpu_enable) begin
                step_count <= step_count + 16'd1;
            end

            presc     <= presc_nxt;
            digit_idx <= idx_nxt;
            snapshot  <= snap_nxt;
            seg_an    <= ~(4'b0001 << idx_nxt);
            seg_cat   <= hex7(nibble_nxt);
        end
    end

endmodule
